// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter on the CPU data port.
//
// The CPU pushes bytes into a DEPTH-entry FIFO through TXDATA. A bit-timer
// driven state machine serialises them LSB first on tx. STATUS and DIV can be
// read combinationally, so a single-cycle CPU can poll them with plain loads.
//
// Register window (selected when daddr[31:4] == BASE_ADDR[31:4]):
//   0x0 TXDATA  write dwe[0]: push dwdata[7:0]; reads 0
//   0x4 STATUS  {16'b0, count, 3'b0, parityEn, overflow, busy, full, empty}
//               write dwe[0] with dwdata[3]=1 clears overflow
//   0x8 DIV     {16'b0, div}; dwe[0] writes div[7:0], dwe[1] writes div[15:8]
//   0xC         reads 0, writes ignored
//
// Ports:
//   clk     single clock, rising edge
//   reset   asynchronous active-high reset
//   daddr   CPU data address
//   dwdata  CPU write data
//   dwe     per-byte write enables
//   drdata  combinational read data, 0 outside the window
//   tx      serial line, idles high
//
// Build option: define MMIO_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (STATUS bit 4 then reads 1).

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        tx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic       PAR_FLAG = 1'b1;
`else
  localparam logic       PAR_FLAG = 1'b0;
`endif

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   div;

  logic [2:0]    state;
  logic [7:0]    shiftReg;
  logic [15:0]   bitTimer;
  logic [15:0]   reload;
  logic [2:0]    bitIdx;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          parityBit;
`endif

  logic       sel;
  logic [1:0] regSel;
  logic       wrTx;
  logic       wrStat;
  logic       wrDivLo;
  logic       wrDivHi;
  logic       empty;
  logic       full;
  logic       busy;
  logic       pushOk;
  logic       pop;
  logic       timerDone;
  logic [7:0] head;
  logic [7:0] countField;

  // Byte lanes and address bits that no register looks at.
  logic unusedBits;
  assign unusedBits = &{1'b0, daddr[1:0], dwdata[31:16], dwe[3:2]};

  assign sel     = (daddr[31:4] == BASE_ADDR[31:4]);
  assign regSel  = daddr[3:2];
  assign wrTx    = sel && (regSel == 2'd0) && dwe[0];
  assign wrStat  = sel && (regSel == 2'd1) && dwe[0];
  assign wrDivLo = sel && (regSel == 2'd2) && dwe[0];
  assign wrDivHi = sel && (regSel == 2'd2) && dwe[1];

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign busy       = (state != IDLE);
  assign pushOk     = wrTx && !full;
  assign timerDone  = (bitTimer == reload);
  assign head       = mem[rdPtr];
  assign countField = 8'(count);

  // A byte leaves the FIFO either from idle or right at the end of a stop
  // bit, which is what makes consecutive frames abut with no idle gap.
  assign pop = !empty && ((state == IDLE) || ((state == STOP) && timerDone));

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= dwdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({pushOk, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow is sticky; a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wrTx && full) begin
      overflow <= 1'b1;
    end else if (wrStat && dwdata[3]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= DIV_RESET;
    end else begin
      if (wrDivLo) begin
        div[7:0] <= dwdata[7:0];
      end
      if (wrDivHi) begin
        div[15:8] <= dwdata[15:8];
      end
    end
  end

  // The divisor is snapshotted into reload at each pop, so a DIV write only
  // takes effect from the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitTimer <= '0;
      reload   <= '0;
      bitIdx   <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else if (pop) begin
      state    <= START;
      shiftReg <= head;
      reload   <= div;
      bitTimer <= '0;
      bitIdx   <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parityBit <= ^head;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        START: begin
          if (timerDone) begin
            bitTimer <= '0;
            state    <= DATA;
          end else begin
            bitTimer <= bitTimer + 16'd1;
          end
        end
        DATA: begin
          if (timerDone) begin
            bitTimer <= '0;
            if (bitIdx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitIdx   <= bitIdx + 3'd1;
            end
          end else begin
            bitTimer <= bitTimer + 16'd1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY: begin
          if (timerDone) begin
            bitTimer <= '0;
            state    <= STOP;
          end else begin
            bitTimer <= bitTimer + 16'd1;
          end
        end
`endif
        STOP: begin
          if (timerDone) begin
            bitTimer <= '0;
            state    <= IDLE;
          end else begin
            bitTimer <= bitTimer + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shiftReg[0];
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY:  tx = parityBit;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    drdata = '0;
    if (sel) begin
      case (regSel)
        2'd1:    drdata = {16'b0, countField, 3'b0, PAR_FLAG, overflow, busy, full, empty};
        2'd2:    drdata = {16'b0, div};
        default: drdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: register vectors from a table, plus a serial
// monitor that decodes tx frames and compares them against a scoreboard of
// bytes queued by the stimulus.

module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PAR_FLAG   = 32'h10;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PAR_FLAG   = 32'h00;
`endif
  localparam logic [31:0] IDLE_STATUS = 32'h1 | PAR_FLAG;

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] expRd;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         period;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        tx;

  int    checks;
  int    failures;
  sb_t   sbQ[$];
  longint startQ[$];
  longint cycleCount;
  bit    monEnable;
  bit    monBusy;
  vec_t  vecs[20];

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .DEPTH(8),
    .DIV_RESET(16'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .daddr(daddr),
    .dwdata(dwdata),
    .dwe(dwe),
    .drdata(drdata),
    .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Called at posedge+1; the write lands on the next rising edge.
  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    daddr  = addr;
    dwdata = data;
    dwe    = we;
    @(posedge clk);
    #1;
    dwe    = 4'b0;
    daddr  = 32'h0;
    dwdata = 32'h0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    daddr = addr;
    dwe   = 4'b0;
    @(negedge clk);
    data = drdata;
    @(posedge clk);
    #1;
    daddr = 32'h0;
  endtask

  task automatic pushByte(input logic [7:0] data, input int period);
    sbQ.push_back('{data, period});
    busWrite(BASE, {24'b0, data}, 4'b0001);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    if (v.isWrite) begin
      busWrite(v.addr, v.wdata, v.we);
    end else begin
      busRead(v.addr, rd);
      checkOutput($sformatf("vec%0d_rd", idx), rd, v.expRd);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int k;
    k = 0;
    while ((sbQ.size() != 0 || monBusy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, 32'(sbQ.size() != 0 || monBusy), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Serial monitor: each bit is checked on its first and last clock so an
  // off-by-one bit period is caught, not just a wrong data value.
  initial begin : monitor
    sb_t         exp;
    logic [10:0] bits;
    logic [7:0]  got;
    bit          ok;
    bit          aborted;
    int          nBits;
    monBusy = 0;
    forever begin
      @(negedge clk);
      if (monEnable && !reset && tx === 1'b0) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedFrame", 32'h1, 32'h0);
          for (int k = 0; k < 2000 && tx !== 1'b1; k++) @(negedge clk);
        end else begin
          exp = sbQ[0];
          monBusy = 1;
          startQ.push_back(cycleCount);
          bits = '1;
          bits[0] = 1'b0;
          bits[8:1] = exp.data;
`ifdef MMIO_UART_TX_PARITY_EN
          bits[9] = ^exp.data;
`endif
          nBits = FRAME_BITS;
          ok = 1;
          aborted = 0;
          got = '0;
          for (int b = 0; b < nBits && !aborted; b++) begin
            for (int c = 0; c < exp.period && !aborted; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (!monEnable || reset) begin
                aborted = 1;
              end else begin
                if ((c == 0 || c == exp.period - 1) && tx !== bits[b]) ok = 0;
                if (c == exp.period - 1 && b >= 1 && b <= 8) got[b-1] = tx;
              end
            end
          end
          if (!aborted) begin
            void'(sbQ.pop_front());
            // Bit 8 of the compared word flags a bit-timing error.
            checkOutput($sformatf("frame_%02h", exp.data), {23'b0, ~ok, got}, {24'b0, exp.data});
          end
          monBusy = 0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] rd;
    int          n;
    bit          stop;
    checks     = 0;
    failures   = 0;
    cycleCount = 0;
    monEnable  = 1;
    reset  = 1'b1;
    daddr  = 32'h0;
    dwdata = 32'h0;
    dwe    = 4'b0;

    vecs[0]  = '{0, BASE + 32'h4,  32'h0,         4'b0000, IDLE_STATUS};
    vecs[1]  = '{0, BASE + 32'h8,  32'h0,         4'b0000, 32'h0000_0003};
    vecs[2]  = '{0, 32'h0,         32'h0,         4'b0000, 32'h0};
    vecs[3]  = '{0, BASE,          32'h0,         4'b0000, 32'h0};
    vecs[4]  = '{0, BASE + 32'hC,  32'h0,         4'b0000, 32'h0};
    vecs[5]  = '{1, BASE + 32'h8,  32'h0000_1234, 4'b0001, 32'h0};
    vecs[6]  = '{0, BASE + 32'h8,  32'h0,         4'b0000, 32'h0000_0034};
    vecs[7]  = '{1, BASE + 32'h8,  32'h0000_AB00, 4'b0010, 32'h0};
    vecs[8]  = '{0, BASE + 32'h8,  32'h0,         4'b0000, 32'h0000_AB34};
    vecs[9]  = '{1, 32'h0000_0418, 32'h0000_0005, 4'b1111, 32'h0};
    vecs[10] = '{0, BASE + 32'h8,  32'h0,         4'b0000, 32'h0000_AB34};
    vecs[11] = '{1, BASE + 32'h8,  32'h0000_0099, 4'b1100, 32'h0};
    vecs[12] = '{0, BASE + 32'h8,  32'h0,         4'b0000, 32'h0000_AB34};
    vecs[13] = '{1, BASE,          32'h0000_0042, 4'b1110, 32'h0};
    vecs[14] = '{1, BASE + 32'hC,  32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[15] = '{1, BASE + 32'h4,  32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[16] = '{0, BASE + 32'h4,  32'h0,         4'b0000, IDLE_STATUS};
    vecs[17] = '{1, BASE + 32'h8,  32'hFFFF_0003, 4'b0011, 32'h0};
    vecs[18] = '{0, BASE + 32'h9,  32'h0,         4'b0000, 32'h0000_0003};
    vecs[19] = '{0, 32'h1000_0408, 32'h0,         4'b0000, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("txDuringReset", {31'b0, tx}, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("txAfterReset", {31'b0, tx}, 32'h1);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i], i);
    end

    // 0x55 at DIV=3: pop one edge after the push, busy for one whole frame.
    pushByte(8'h55, 4);
    daddr = BASE + 32'h4;
    @(negedge clk);
    checkOutput("txBeforePop", {31'b0, tx}, 32'h1);
    checkOutput("statusQueued", drdata, 32'h0000_0100 | PAR_FLAG);
    n = 0;
    stop = 0;
    for (int i = 0; i < 400 && !stop; i++) begin
      @(negedge clk);
      if (drdata[2]) n++;
      else stop = 1;
    end
    checkOutput("busyCycles", n, FRAME_BITS * 4);
    @(posedge clk);
    #1;
    daddr = 32'h0;
    waitIdle(500, "drain55");

    // DIV=1: two queued bytes must abut with no idle cycle.
    busWrite(BASE + 32'h8, 32'h0000_0001, 4'b0011);
    startQ.delete();
    pushByte(8'hA5, 2);
    pushByte(8'h3C, 2);
    waitIdle(500, "drainB2B");
    checkOutput("b2bFrames", startQ.size(), 2);
    if (startQ.size() >= 2) checkOutput("b2bGap", 32'(startQ[1] - startQ[0]), FRAME_BITS * 2);

    // DIV changed to 7 mid-frame: current frame keeps 4, the next uses 8.
    busWrite(BASE + 32'h8, 32'h0000_0003, 4'b0011);
    startQ.delete();
    pushByte(8'h96, 4);
    pushByte(8'h0F, 8);
    repeat (10) @(posedge clk);
    #1;
    busWrite(BASE + 32'h8, 32'h0000_0007, 4'b0001);
    waitIdle(2000, "drainDivChange");
    checkOutput("divChangeFrames", startQ.size(), 2);
    if (startQ.size() >= 2) checkOutput("divChangeGap", 32'(startQ[1] - startQ[0]), FRAME_BITS * 4);

    // DIV=0: one clock per bit.
    busWrite(BASE + 32'h8, 32'h0, 4'b0011);
    pushByte(8'hC3, 1);
    waitIdle(200, "drainDiv0");

    // Overflow at a huge divisor: 1 popped, 8 queued, 10th dropped.
    monEnable = 0;
    busWrite(BASE + 32'h8, 32'h0000_FFFF, 4'b0011);
    for (int i = 0; i < 10; i++) begin
      busWrite(BASE, 32'(8'h10 + i), 4'b0001);
    end
    busRead(BASE + 32'h4, rd);
    checkOutput("statusOverflow", rd, 32'h0000_080E | PAR_FLAG);
    checkOutput("txInStart", {31'b0, tx}, 32'h0);
    busWrite(BASE + 32'h4, 32'h0000_00F7, 4'b0001);
    busRead(BASE + 32'h4, rd);
    checkOutput("w1cBit3Clear", rd, 32'h0000_080E | PAR_FLAG);
    busWrite(BASE + 32'h4, 32'h0000_0008, 4'b0001);
    busRead(BASE + 32'h4, rd);
    checkOutput("w1cClear", rd, 32'h0000_0806 | PAR_FLAG);

    // Asynchronous reset with a frame in flight and a full FIFO.
    daddr = BASE + 32'h4;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("txAsyncReset", {31'b0, tx}, 32'h1);
    checkOutput("statusAsyncReset", drdata, IDLE_STATUS);
    @(posedge clk);
    #1;
    reset = 1'b0;
    busRead(BASE + 32'h8, rd);
    checkOutput("divAfterReset", rd, 32'h0000_0003);

    // Reset during data bit 4 of 0xEF (only bit 4 is low).
    busWrite(BASE, 32'h0000_00EF, 4'b0001);
    repeat (22) @(posedge clk);
    #1;
    checkOutput("txBit4", {31'b0, tx}, 32'h0);
    daddr = BASE + 32'h4;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("txBit4Reset", {31'b0, tx}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    busRead(BASE + 32'h4, rd);
    checkOutput("statusAfterBit4Reset", rd, IDLE_STATUS);
    monEnable = 1;

    // Parity examples and recovery after reset.
    pushByte(8'h07, 4);
    pushByte(8'h03, 4);
    waitIdle(500, "drainParity");

    checkOutput("sbDrained", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
